// File: rtl/cdp_rdma_reg_group_ctrl.sv
// cdp_rdma_reg_group_ctrl: ping-pong op_en launch/retire control for the two CDP RDMA register groups.
// Optional per-layer active-cycle counter enabled by defining CDP_RDMA_PERF_CNT_EN.
module cdp_rdma_reg_group_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              producer,
  input  logic              op_en_wr_en,
  input  logic              op_en_wr_data,
  input  logic              dp2reg_done,
  output logic              consumer,
  output logic [1:0]        status_0,
  output logic [1:0]        status_1,
  output logic              reg2dp_op_en,
  output logic              op_en_0,
  output logic              op_en_1,
  output logic [1:0]        done_intr,
  output logic              err_pulse,
  output logic [PERF_W-1:0] perf_active_cycles
);
  logic [1:0] op_en_q, op_en_d, done_intr_q, done_intr_d;
  logic       consumer_q, consumer_d, run_q, run_d, err_q, err_d;
  logic       wr1, done_v, retire_hit;
  always_comb begin
    wr1         = op_en_wr_en & op_en_wr_data;
    done_v      = dp2reg_done & run_q;
    retire_hit  = done_v & (producer == consumer_q);
    // clear the retiring group first so a colliding write-1 to it survives
    op_en_d     = (op_en_q & ~({1'b0, done_v} << consumer_q)) | ({1'b0, wr1} << producer);
    consumer_d  = consumer_q ^ done_v;
    run_d       = ~dp2reg_done & op_en_q[consumer_q];
    done_intr_d = {done_v & consumer_q, done_v & ~consumer_q};
    err_d       = (wr1 & op_en_q[producer] & ~retire_hit) | (dp2reg_done & ~run_q);
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      op_en_q     <= '0;
      consumer_q  <= 1'b0;
      run_q       <= 1'b0;
      done_intr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      op_en_q     <= op_en_d;
      consumer_q  <= consumer_d;
      run_q       <= run_d;
      done_intr_q <= done_intr_d;
      err_q       <= err_d;
    end
  assign consumer     = consumer_q;
  assign reg2dp_op_en = run_q;
  assign op_en_0      = op_en_q[0];
  assign op_en_1      = op_en_q[1];
  assign done_intr    = done_intr_q;
  assign err_pulse    = err_q;
  assign status_0     = !op_en_q[0] ? 2'd0 : (consumer_q ? 2'd2 : 2'd1);
  assign status_1     = !op_en_q[1] ? 2'd0 : (consumer_q ? 2'd1 : 2'd2);
`ifdef CDP_RDMA_PERF_CNT_EN
  logic [PERF_W-1:0] cnt_q, cnt_d, cnt_inc, perf_q, perf_d;
  always_comb begin
    cnt_inc = &cnt_q ? cnt_q : cnt_q + PERF_W'(1);
    cnt_d   = done_v ? '0 : (run_q ? cnt_inc : cnt_q);
    perf_d  = done_v ? cnt_inc : perf_q;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  assign perf_active_cycles = perf_q;
`else
  assign perf_active_cycles = '0;
`endif
endmodule

// File: doc/cdp_rdma_reg_group_ctrl.md
Name: cdp_rdma_reg_group_ctrl

Overview:
Dual-register-group launch controller for the CDP read DMA. Consumes `producer` from the CDP RDMA single-register block and returns `consumer`, `status_0` and `status_1` to it. Owns the per-group op_en flops and drives the registered operation enable to the RDMA datapath. Retires groups on datapath done, ping-ponging between the two groups.

Parameters:
PERF_W, 32, width of the optional per-layer active-cycle counter.

Ports:
- nvdla_core_clk  input  1  core clock; single clock domain.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- producer  input  1  group targeted by software writes (0/1).
- op_en_wr_en  input  1  one-cycle write strobe to D_OP_ENABLE of group `producer`.
- op_en_wr_data  input  1  bit 0 of the write data.
- dp2reg_done  input  1  one-cycle pulse: datapath finished the active layer.
- consumer  output  1  group currently owned by the datapath.
- status_0  output  2  group 0 state: 0 IDLE, 1 RUNNING, 2 PENDING.
- status_1  output  2  group 1 state, same encoding.
- reg2dp_op_en  output  1  registered enable to the datapath for group `consumer`.
- op_en_0  output  1  group 0 op_en flop; readback for the dual-register read mux.
- op_en_1  output  1  group 1 op_en flop; readback for the dual-register read mux.
- done_intr  output  2  one-cycle pulse one cycle after done; bit g set when group g retired.
- err_pulse  output  1  one-cycle protocol-error pulse.
- perf_active_cycles  output  PERF_W  latched active cycles of the last layer (optional feature).

Behaviour:
- Reset values (asynchronous, on `nvdla_core_rstn` low): consumer=0, op_en_0=op_en_1=0, reg2dp_op_en=0, done_intr=0, err_pulse=0, perf_active_cycles=0. status_0 and status_1 therefore read IDLE.
- Reset asserted mid-layer clears all state immediately. No done interrupt is emitted for the aborted layer.
- Write handling: `op_en_wr_en` & `op_en_wr_data`=1 sets op_en[producer] at the next edge.
  - A write of 0 is ignored; software cannot clear op_en.
  - A write of 1 to a group whose op_en is already 1 is ignored and pulses err_pulse the next cycle.
- Status (combinational from the flops), per group g:
  - op_en[g]=0 -> IDLE.
  - op_en[g]=1 and consumer==g -> RUNNING.
  - op_en[g]=1 and consumer!=g -> PENDING.
- reg2dp_op_en next-state:
  - 0 if dp2reg_done is high in this cycle.
  - Otherwise op_en[consumer] as held in the flops this cycle.
  - Latency: write at edge N sets op_en; reg2dp_op_en rises at edge N+1 if the written group is the consumer.
- Done handling (dp2reg_done=1 and reg2dp_op_en=1), at the next edge:
  - op_en[consumer] cleared.
  - consumer toggles.
  - reg2dp_op_en forced to 0.
  - done_intr[old consumer] pulses for one cycle.
  - At the following edge reg2dp_op_en follows op_en[new consumer]. This gives exactly one dead cycle between back-to-back layers.
- Done with reg2dp_op_en=0 is spurious: no state change, err_pulse fires for one cycle.
- Simultaneous write-1 and done:
  - Write targets the retiring group: the write wins, op_en stays 1, and the group becomes PENDING after consumer toggles.
  - Write targets the other group: both actions apply.
- Consumer wrap: 1 -> 0 toggles freely with no limit.
- Both groups PENDING or RUNNING at once is legal. Processing order is strictly alternating.
- No combinational path from any input to reg2dp_op_en, done_intr or err_pulse.

Optional Feature:
Macro CDP_RDMA_PERF_CNT_EN.
- Defined:
  - A PERF_W counter increments each cycle reg2dp_op_en=1 and saturates at all-ones.
  - On a valid done, the counter value plus 1 (for the done cycle, saturating) is latched into perf_active_cycles, and the counter clears.
  - Reset clears both.
- Undefined: perf_active_cycles is tied to 0 and no counter flops exist.

Test Plan:
1. Single layer: reset; producer=0, write 1 -> reg2dp_op_en=1 one cycle later, status_0=1, status_1=0. After 10 cycles pulse done -> next cycle consumer=1, status_0=0, done_intr=2'b01, reg2dp_op_en=0.
2. Ping-pong: program group 0 then group 1 (producer=1) -> status_1=2 (PENDING). Done on group 0 -> reg2dp_op_en low exactly 1 cycle, then high with consumer=1 and status_1=1. Second done -> done_intr=2'b10, consumer wraps to 0.
3. Errors: write 1 twice to group 0 -> err_pulse once, state unchanged. Done while idle -> err_pulse, consumer unchanged. Write 0 while RUNNING -> no effect.
4. Collision: group 0 RUNNING, producer=0 write-1 in the same cycle as done -> op_en_0 stays 1, consumer=1, status_0=2. Group 0 launches after group 1 is programmed and retires.
5. Reset mid-layer: assert nvdla_core_rstn low while RUNNING -> all outputs 0 / IDLE immediately, no done_intr pulse.
6. With CDP_RDMA_PERF_CNT_EN: reg2dp_op_en high for 100 cycles before done -> perf_active_cycles=101. Without the macro -> perf_active_cycles=0 always.
